// File: rtl/conv_accum_scheduler_if.sv
// conv_accum_scheduler_if: frame control, partial-sum input, adder AXIS and output BRAM signals.
// Rev 1.0
`default_nettype none

interface conv_accum_scheduler_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic                  start;
  logic                  busy;
  logic                  frame_done;
  logic                  in_valid;
  logic                  in_ready;
  logic [3*DATA_W-1:0]   in_data;
  logic [DATA_W-1:0]     add_a_tdata;
  logic                  add_a_tvalid;
  logic                  add_a_tready;
  logic [DATA_W-1:0]     add_b_tdata;
  logic                  add_b_tvalid;
  logic                  add_b_tready;
  logic [DATA_W-1:0]     add_res_tdata;
  logic                  add_res_tvalid;
  logic                  add_res_tready;
  logic [ADDR_W-1:0]     out_addr;
  logic [DATA_W-1:0]     out_data;
  logic [1:0]            out_we;

  modport master (
    input  start, in_valid, in_data, add_a_tready, add_b_tready,
           add_res_tdata, add_res_tvalid,
    output busy, frame_done, in_ready, add_a_tdata, add_a_tvalid,
           add_b_tdata, add_b_tvalid, add_res_tready, out_addr, out_data, out_we
  );

  modport slave (
    output start, in_valid, in_data, add_a_tready, add_b_tready,
           add_res_tdata, add_res_tvalid,
    input  busy, frame_done, in_ready, add_a_tdata, add_a_tvalid,
           add_b_tdata, add_b_tvalid, add_res_tready, out_addr, out_data, out_we
  );
endinterface

`default_nettype wire

// File: rtl/conv_accum_scheduler.sv
// conv_accum_scheduler: reduces ((p0 + p1) + p2) per pixel on one shared fp16 adder.
// Rev 1.0
`default_nettype none

module conv_accum_scheduler #(
  parameter int OUT_ROWS = 5,
  parameter int OUT_COLS = 5,
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  conv_accum_scheduler_if.master bus
);

  localparam int ROW_W = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam int COL_W = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OUT_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(OUT_COLS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    ISSUE1 = 3'd2,
    WAIT1  = 3'd3,
    ISSUE2 = 3'd4,
    WAIT2  = 3'd5,
    WRITE  = 3'd6
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic [DATA_W-1:0]  p2;
  logic               a_fire;
  logic               b_fire;
  logic               issue_done;
  logic               last_pixel;

  assign a_fire     = bus.add_a_tvalid && bus.add_a_tready;
  assign b_fire     = bus.add_b_tvalid && bus.add_b_tready;
  // Both operand channels are finished once each has either handshaken earlier or does so now.
  assign issue_done = (!bus.add_a_tvalid || bus.add_a_tready) &&
                      (!bus.add_b_tvalid || bus.add_b_tready);
  assign last_pixel = (row == LAST_ROW) && (col == LAST_COL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next         = state;
    bus.in_ready       = 1'b0;
    bus.add_res_tready = 1'b0;
    bus.out_we         = 2'b00;
    case (state)
      IDLE: begin
        // Draining here discards any result left in flight by a reset.
        bus.add_res_tready = 1'b1;
        if (bus.start) state_next = ACCEPT;
      end
      ACCEPT: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = ISSUE1;
      end
      ISSUE1: if (issue_done) state_next = WAIT1;
      WAIT1: begin
        bus.add_res_tready = 1'b1;
        if (bus.add_res_tvalid) state_next = ISSUE2;
      end
      ISSUE2: if (issue_done) state_next = WAIT2;
      WAIT2: begin
        bus.add_res_tready = 1'b1;
        if (bus.add_res_tvalid) state_next = WRITE;
      end
      WRITE: begin
        bus.out_we = 2'b11;
        state_next = last_pixel ? IDLE : ACCEPT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy         <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.add_a_tvalid <= 1'b0;
      bus.add_b_tvalid <= 1'b0;
      bus.add_a_tdata  <= '0;
      bus.add_b_tdata  <= '0;
      bus.out_addr     <= '0;
      bus.out_data     <= '0;
      row              <= '0;
      col              <= '0;
      p2               <= '0;
    end else begin
      bus.frame_done <= 1'b0;
      if (a_fire) bus.add_a_tvalid <= 1'b0;
      if (b_fire) bus.add_b_tvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            row      <= '0;
            col      <= '0;
          end
        end
        ACCEPT: begin
          if (bus.in_valid) begin
            bus.add_a_tdata  <= bus.in_data[DATA_W-1:0];
            bus.add_b_tdata  <= bus.in_data[2*DATA_W-1:DATA_W];
            p2               <= bus.in_data[3*DATA_W-1:2*DATA_W];
            bus.add_a_tvalid <= 1'b1;
            bus.add_b_tvalid <= 1'b1;
          end
        end
        WAIT1: begin
          if (bus.add_res_tvalid) begin
            bus.add_a_tdata  <= bus.add_res_tdata;
            bus.add_b_tdata  <= p2;
            bus.add_a_tvalid <= 1'b1;
            bus.add_b_tvalid <= 1'b1;
          end
        end
        WAIT2: begin
          if (bus.add_res_tvalid) begin
            bus.out_data <= bus.add_res_tdata;
            bus.out_addr <= ADDR_W'(row) * ADDR_W'(OUT_COLS) + ADDR_W'(col);
          end
        end
        WRITE: begin
          if (last_pixel) begin
            bus.frame_done <= 1'b1;
            bus.busy       <= 1'b0;
          end else if (col == LAST_COL) begin
            col <= '0;
            row <= row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_accum_scheduler.sv
// tb_conv_accum_scheduler: directed tests of the shared-adder scheduler (5x5 and 2x3 frames).
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_conv_accum_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_accum_scheduler_if #(.ADDR_W(18), .DATA_W(16)) bus ();
  conv_accum_scheduler_if #(.ADDR_W(18), .DATA_W(16)) bus2 ();

  conv_accum_scheduler #(.OUT_ROWS(5), .OUT_COLS(5), .ADDR_W(18), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  conv_accum_scheduler #(.OUT_ROWS(2), .OUT_COLS(3), .ADDR_W(18), .DATA_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  localparam logic [47:0] PAT_A = {16'h4200, 16'h4000, 16'h3C00}; // 1+2=3, 3+3=6
  localparam logic [47:0] PAT_B = {16'h4400, 16'h4000, 16'h4000}; // 2+2=4, 4+4=8
  localparam logic [47:0] PAT_C = {16'h3C00, 16'h3C00, 16'h3C00}; // 1+1=2, 2+1=3

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic m_en = 1'b0;

  // Order-sensitive table: unlisted operand pairs give 16'hBAD0.
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      {16'h3C00, 16'h4000}: return 16'h4200;
      {16'h4200, 16'h4200}: return 16'h4600;
      {16'h4000, 16'h4000}: return 16'h4400;
      {16'h4400, 16'h4400}: return 16'h4800;
      {16'h3C00, 16'h3C00}: return 16'h4000;
      {16'h4000, 16'h3C00}: return 16'h4200;
      default:              return 16'hBAD0;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Adder model for dut: latency 3, readies driven by the tests.
  logic [15:0] ma, mb, mres, hold_a, hold_b;
  logic ha = 0, hb = 0, pend = 0, held_a = 0, held_b = 0;
  int cd = 0, n_a_hs = 0, n_b_hs = 0, n_adds = 0, stab_err = 0;
  always @(posedge clk) begin
    if (!m_en) begin
      bus.add_res_tvalid <= 1'b0;
      bus.add_res_tdata  <= 16'h0;
    end else begin
      if (rst_n && held_a && (!bus.add_a_tvalid || bus.add_a_tdata != hold_a)) stab_err++;
      if (rst_n && held_b && (!bus.add_b_tvalid || bus.add_b_tdata != hold_b)) stab_err++;
      held_a = bus.add_a_tvalid && !bus.add_a_tready;
      held_b = bus.add_b_tvalid && !bus.add_b_tready;
      hold_a = bus.add_a_tdata;
      hold_b = bus.add_b_tdata;
      if (bus.add_a_tvalid && bus.add_a_tready) begin ma = bus.add_a_tdata; ha = 1; n_a_hs++; end
      if (bus.add_b_tvalid && bus.add_b_tready) begin mb = bus.add_b_tdata; hb = 1; n_b_hs++; end
      if (ha && hb) begin ha = 0; hb = 0; mres = fp_add(ma, mb); cd = 3; pend = 1; n_adds++; end
      if (bus.add_res_tvalid && bus.add_res_tready) bus.add_res_tvalid <= 1'b0;
      if (pend) begin
        cd--;
        if (cd == 0) begin bus.add_res_tvalid <= 1'b1; bus.add_res_tdata <= mres; pend = 0; end
      end
    end
  end

  // Adder model for dut2: latency 1, readies always high.
  logic [15:0] ma2, mb2;
  logic ha2 = 0, hb2 = 0;
  always @(posedge clk) begin
    if (!m_en) begin
      bus2.add_res_tvalid <= 1'b0;
      bus2.add_res_tdata  <= 16'h0;
    end else begin
      if (bus2.add_a_tvalid && bus2.add_a_tready) begin ma2 = bus2.add_a_tdata; ha2 = 1; end
      if (bus2.add_b_tvalid && bus2.add_b_tready) begin mb2 = bus2.add_b_tdata; hb2 = 1; end
      if (bus2.add_res_tvalid && bus2.add_res_tready) bus2.add_res_tvalid <= 1'b0;
      if (ha2 && hb2) begin
        ha2 = 0; hb2 = 0;
        bus2.add_res_tvalid <= 1'b1;
        bus2.add_res_tdata  <= fp_add(ma2, mb2);
      end
    end
  end

  // Write / frame_done monitors, sampled mid-cycle.
  logic [17:0] wr_addr[$];
  logic [15:0] wr_data[$];
  logic [17:0] wr2_addr[$];
  logic [15:0] wr2_data[$];
  int we_bad = 0, fd_cnt = 0, fd_busy_err = 0, last_wr_cyc = 0, fd_cyc = 0, adder_busy_cnt = 0;
  int fd2_cnt = 0, last_wr2_cyc = 0, fd2_cyc = 0;
  always @(negedge clk) begin
    if (bus.out_we != 2'b00) begin
      wr_addr.push_back(bus.out_addr);
      wr_data.push_back(bus.out_data);
      last_wr_cyc = cyc;
      if (bus.out_we != 2'b11) we_bad++;
    end
    if (bus.frame_done) begin fd_cnt++; fd_cyc = cyc; if (bus.busy) fd_busy_err++; end
    if (bus.add_a_tvalid || bus.add_b_tvalid) adder_busy_cnt++;
    if (bus2.out_we != 2'b00) begin
      wr2_addr.push_back(bus2.out_addr);
      wr2_data.push_back(bus2.out_data);
      last_wr2_cyc = cyc;
    end
    if (bus2.frame_done) begin fd2_cnt++; fd2_cyc = cyc; end
  end

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic send_pixel(input logic [47:0] d);
    int i;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    i = 0;
    while (!bus.in_ready && i < 300) begin @(negedge clk); i++; end
    if (!bus.in_ready) begin
      checks++; failures++;
      $display("FAIL send_pixel: in_ready=%0b after %0d cycles, required 1", bus.in_ready, i);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_frame_done(input int base);
    int i = 0;
    while (fd_cnt == base && i < 1000) begin @(negedge clk); i++; end
    checks++;
    if (fd_cnt == base) begin
      failures++;
      $display("FAIL frame_done_timeout: fd_cnt=%0d, required >%0d", fd_cnt, base);
    end
  endtask

  task automatic wait_writes(input int n);
    int i = 0;
    while (wr_addr.size() < n && i < 1000) begin @(negedge clk); i++; end
    checks++;
    if (wr_addr.size() < n) begin
      failures++;
      $display("FAIL write_timeout: writes=%0d, required %0d", wr_addr.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    m_en = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b, required 0", bus.busy); end
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %0b, required 0", bus.frame_done); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %0b, required 0", bus.in_ready); end
    checks++; if ({bus.add_a_tvalid, bus.add_b_tvalid} !== 2'b00) begin failures++; $display("FAIL reset_tvalid: got %b, required 00", {bus.add_a_tvalid, bus.add_b_tvalid}); end
    checks++; if (bus.out_we !== 2'b00) begin failures++; $display("FAIL reset_out_we: got %b, required 00", bus.out_we); end
    checks++; if (bus.out_addr !== 18'd0 || bus.out_data !== 16'h0) begin failures++; $display("FAIL reset_out: addr=%0d data=%h, required 0/0000", bus.out_addr, bus.out_data); end
    checks++; if (bus.add_a_tdata !== 16'h0 || bus.add_b_tdata !== 16'h0) begin failures++; $display("FAIL reset_tdata: a=%h b=%h, required 0000", bus.add_a_tdata, bus.add_b_tdata); end
    checks++; if (bus.add_res_tready !== 1'b1) begin failures++; $display("FAIL idle_res_tready: got %0b, required 1", bus.add_res_tready); end
  endtask

  task automatic test_full_frame();
    int wb = wr_addr.size(), fb = fd_cnt, fbe = fd_busy_err, ab = n_adds, bad = 0;
    pulse_start();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL start_busy: got %0b, required 1", bus.busy); end
    for (int p = 0; p < 25; p++) send_pixel(PAT_A);
    wait_frame_done(fb);
    checks++; if (wr_addr.size() - wb != 25) begin failures++; $display("FAIL frame_write_count: got %0d, required 25", wr_addr.size() - wb); end
    for (int k = 0; k < 25 && wb + k < wr_addr.size(); k++)
      if (wr_addr[wb+k] !== 18'(k) || wr_data[wb+k] !== 16'h4600) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL frame_addr_data: %0d writes wrong, required addr 0..24 data 4600", bad); end
    checks++; if (fd_cnt - fb != 1) begin failures++; $display("FAIL frame_done_count: got %0d, required 1", fd_cnt - fb); end
    checks++; if (fd_busy_err != fbe || bus.busy !== 1'b0) begin failures++; $display("FAIL frame_busy_fall: busy_at_done_errs=%0d busy=%0b, required 0/0", fd_busy_err - fbe, bus.busy); end
    checks++; if (fd_cyc != last_wr_cyc + 1) begin failures++; $display("FAIL frame_done_timing: done cycle %0d, required %0d", fd_cyc, last_wr_cyc + 1); end
    checks++; if (n_adds - ab != 50) begin failures++; $display("FAIL frame_add_count: got %0d, required 50", n_adds - ab); end
    checks++; if (we_bad != 0) begin failures++; $display("FAIL out_we_value: %0d bad enables, required 0", we_bad); end
  endtask

  task automatic test_b_stall();
    int wb = wr_addr.size(), fb = fd_cnt, ahb = n_a_hs, bhb = n_b_hs, sb = stab_err, bad = 0;
    pulse_start();
    bus.add_b_tready = 1'b0;
    send_pixel(PAT_C);
    @(negedge clk);
    checks++; if ({bus.add_a_tvalid, bus.add_b_tvalid} !== 2'b11) begin failures++; $display("FAIL issue_entry_valid: got %b, required 11", {bus.add_a_tvalid, bus.add_b_tvalid}); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.add_a_tvalid !== 1'b0 || bus.add_b_tvalid !== 1'b1 || bus.add_b_tdata !== 16'h3C00) begin
        failures++;
        $display("FAIL b_stall_hold: a_valid=%0b b_valid=%0b b_data=%h, required 0/1/3c00", bus.add_a_tvalid, bus.add_b_tvalid, bus.add_b_tdata);
      end
    end
    bus.add_b_tready = 1'b1;
    @(negedge clk);
    checks++; if (bus.add_b_tvalid !== 1'b0) begin failures++; $display("FAIL b_drop: got %0b, required 0", bus.add_b_tvalid); end
    checks++; if (n_a_hs - ahb != 1 || n_b_hs - bhb != 1) begin failures++; $display("FAIL b_stall_single_issue: a_hs=%0d b_hs=%0d, required 1/1", n_a_hs - ahb, n_b_hs - bhb); end
    for (int p = 1; p < 25; p++) send_pixel(PAT_C);
    wait_frame_done(fb);
    for (int k = 0; k < 25 && wb + k < wr_addr.size(); k++)
      if (wr_addr[wb+k] !== 18'(k) || wr_data[wb+k] !== 16'h4200) bad++;
    checks++; if (bad != 0 || wr_addr.size() - wb != 25) begin failures++; $display("FAIL b_stall_frame: %0d wrong of %0d writes, required 0 of 25 (data 4200)", bad, wr_addr.size() - wb); end
    checks++; if (stab_err != sb) begin failures++; $display("FAIL operand_stability: %0d violations, required 0", stab_err - sb); end
  endtask

  task automatic test_input_gap();
    int wb = wr_addr.size(), fb = fd_cnt, bad = 0, gap_wb, gap_ab, gap_busy;
    pulse_start();
    for (int p = 0; p < 3; p++) send_pixel(PAT_B);
    wait_writes(wb + 3);
    @(negedge clk);
    gap_wb = wr_addr.size(); gap_ab = n_a_hs; gap_busy = adder_busy_cnt;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL gap_in_ready: got %0b, required 1", bus.in_ready); end
    end
    checks++; if (wr_addr.size() != gap_wb || n_a_hs != gap_ab || adder_busy_cnt != gap_busy) begin
      failures++; $display("FAIL gap_quiet: writes=%0d adder_cycles=%0d, required 0/0", wr_addr.size() - gap_wb, adder_busy_cnt - gap_busy); end
    for (int p = 3; p < 25; p++) send_pixel(PAT_B);
    wait_frame_done(fb);
    for (int k = 0; k < 25 && wb + k < wr_addr.size(); k++)
      if (wr_addr[wb+k] !== 18'(k) || wr_data[wb+k] !== 16'h4800) bad++;
    checks++; if (bad != 0 || wr_addr.size() - wb != 25) begin failures++; $display("FAIL gap_frame: %0d wrong of %0d writes, required 0 of 25 (data 4800)", bad, wr_addr.size() - wb); end
  endtask

  task automatic test_start_mid_frame();
    int wb = wr_addr.size(), fb = fd_cnt, bad = 0;
    pulse_start();
    for (int p = 0; p < 7; p++) send_pixel(PAT_A);
    wait_writes(wb + 7);
    pulse_start();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_start_busy: got %0b, required 1", bus.busy); end
    for (int p = 7; p < 25; p++) send_pixel(PAT_A);
    wait_frame_done(fb);
    for (int k = 0; k < 25 && wb + k < wr_addr.size(); k++)
      if (wr_addr[wb+k] !== 18'(k) || wr_data[wb+k] !== 16'h4600) bad++;
    checks++; if (bad != 0 || wr_addr.size() - wb != 25) begin failures++; $display("FAIL mid_start_frame: %0d wrong of %0d writes, required 0 of 25", bad, wr_addr.size() - wb); end
    checks++; if (fd_cnt - fb != 1) begin failures++; $display("FAIL mid_start_done_count: got %0d, required 1", fd_cnt - fb); end
  endtask

  task automatic test_reset_mid_frame();
    int wb = wr_addr.size(), ab, i, rwb, fb, bad = 0;
    pulse_start();
    for (int p = 0; p < 12; p++) send_pixel(PAT_A);
    wait_writes(wb + 12);
    ab = n_adds;
    send_pixel(PAT_A);
    i = 0;
    while (n_adds - ab < 2 && i < 200) begin @(negedge clk); i++; end
    checks++; if (n_adds - ab != 2) begin failures++; $display("FAIL reach_wait2: adds=%0d, required 2", n_adds - ab); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_we !== 2'b00) begin
      failures++; $display("FAIL async_reset_ctrl: busy=%0b in_ready=%0b we=%b, required 0/0/00", bus.busy, bus.in_ready, bus.out_we); end
    checks++; if (bus.out_addr !== 18'd0 || bus.out_data !== 16'h0 || bus.add_a_tvalid !== 1'b0 || bus.add_b_tvalid !== 1'b0) begin
      failures++; $display("FAIL async_reset_data: addr=%0d data=%h tvalids=%b%b, required 0/0000/00", bus.out_addr, bus.out_data, bus.add_a_tvalid, bus.add_b_tvalid); end
    rwb = wr_addr.size();
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (bus.add_res_tvalid !== 1'b0) begin failures++; $display("FAIL stale_drain: res_tvalid=%0b, required 0", bus.add_res_tvalid); end
    checks++; if (wr_addr.size() != rwb || bus.busy !== 1'b0) begin failures++; $display("FAIL stale_no_write: writes=%0d busy=%0b, required 0/0", wr_addr.size() - rwb, bus.busy); end
    fb = fd_cnt;
    pulse_start();
    for (int p = 0; p < 25; p++) send_pixel(PAT_A);
    wait_frame_done(fb);
    for (int k = 0; k < 25 && rwb + k < wr_addr.size(); k++)
      if (wr_addr[rwb+k] !== 18'(k) || wr_data[rwb+k] !== 16'h4600) bad++;
    checks++; if (bad != 0 || wr_addr.size() - rwb != 25) begin failures++; $display("FAIL post_reset_frame: %0d wrong of %0d writes, required 0 of 25 from addr 0", bad, wr_addr.size() - rwb); end
  endtask

  task automatic test_small_frame();
    int fb = fd2_cnt, i;
    @(negedge clk); bus2.start = 1'b1;
    @(negedge clk); bus2.start = 1'b0;
    for (int p = 0; p < 6; p++) begin
      @(negedge clk);
      bus2.in_valid = 1'b1; bus2.in_data = PAT_C;
      i = 0;
      while (!bus2.in_ready && i < 300) begin @(negedge clk); i++; end
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;
    end
    i = 0;
    while (fd2_cnt == fb && i < 500) begin @(negedge clk); i++; end
    checks++; if (wr2_addr.size() != 6) begin failures++; $display("FAIL small_write_count: got %0d, required 6", wr2_addr.size()); end
    for (int k = 0; k < 6 && k < wr2_addr.size(); k++) begin
      checks++;
      if (wr2_addr[k] !== 18'(k) || wr2_data[k] !== 16'h4200) begin
        failures++; $display("FAIL small_write_%0d: addr=%0d data=%h, required %0d/4200", k, wr2_addr[k], wr2_data[k], k); end
    end
    checks++; if (fd2_cnt - fb != 1 || fd2_cyc != last_wr2_cyc + 1) begin
      failures++; $display("FAIL small_frame_done: count=%0d cycle=%0d, required 1/%0d", fd2_cnt - fb, fd2_cyc, last_wr2_cyc + 1); end
  endtask

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.add_a_tready = 1'b1; bus.add_b_tready = 1'b1;
    bus2.start = 1'b0; bus2.in_valid = 1'b0; bus2.in_data = '0;
    bus2.add_a_tready = 1'b1; bus2.add_b_tready = 1'b1;
    test_reset();
    test_full_frame();
    test_b_stall();
    test_input_gap();
    test_start_mid_frame();
    test_reset_mid_frame();
    test_small_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/conv_accum_scheduler.md
Name: conv_accum_scheduler

Overview:
Sequences one shared fp16 float_adder instance to reduce three per-pixel convolution partial sums into one output pixel, as ((p0 + p1) + p2). Writes each result to the output BRAM at a row-major address. It replaces the free-running three-adder tree with a single time-shared adder plus valid/ready flow control and frame-level address generation. It sits between the convolution multiply stage, which supplies packed partial sums, and the output BRAM port.

Parameters:
OUT_ROWS, 5, output rows per frame
OUT_COLS, 5, output columns per frame
ADDR_W, 18, output BRAM address width
DATA_W, 16, fp16 word width; the packed input width is 3*DATA_W

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a frame
busy  out  1  high from an accepted start until frame_done
frame_done  out  1  one-cycle pulse after the last pixel write
in_valid  in  1  partial-sum word valid
in_ready  out  1  scheduler can accept a partial-sum word
in_data  in  48  {p2[47:32], p1[31:16], p0[15:0]}
add_a_tdata  out  16  adder operand A
add_a_tvalid  out  1  operand A valid
add_a_tready  in  1  adder accepts A
add_b_tdata  out  16  adder operand B
add_b_tvalid  out  1  operand B valid
add_b_tready  in  1  adder accepts B
add_res_tdata  in  16  adder result
add_res_tvalid  in  1  adder result valid
add_res_tready  out  1  scheduler accepts the result
out_addr  out  ADDR_W  output BRAM address
out_data  out  16  output BRAM write data
out_we  out  2  output BRAM byte write enables

Behaviour:
- Reset: the asynchronous rst_n clears the following:
  - busy, frame_done, in_ready, add_a_tvalid, add_b_tvalid, out_we, row, col → 0
  - out_addr, out_data, add_a_tdata, add_b_tdata → 0
  - state → IDLE
- Reset in mid-operation abandons the current pixel and frame. Nothing is written.
- FSM states: IDLE, ACCEPT, ISSUE1, WAIT1, ISSUE2, WAIT2, WRITE.
- IDLE:
  - A start pulse sets busy and clears row/col, then moves to ACCEPT.
  - start while busy is ignored.
- ACCEPT:
  - in_ready=1.
  - On in_valid&&in_ready, register p0/p1/p2 and move to ISSUE1.
  - in_ready is 0 in every other state.
- ISSUE1:
  - A=p0, B=p1; both tvalids are raised on entry.
  - Each channel's tvalid drops independently in the cycle after its own tready handshake.
  - Advance to WAIT1 once both channels have handshaken, in the same or different cycles.
  - Data is held stable while valid is high.
- WAIT1: on add_res_tvalid, capture the result as s1 and move to ISSUE2.
- ISSUE2: A=s1, B=p2, with the same handshake rules as ISSUE1. Then move to WAIT2.
- WAIT2: on add_res_tvalid, capture the result as s2 and move to WRITE.
- WRITE (exactly one cycle):
  - out_we=2'b11, out_data=s2, out_addr=row*OUT_COLS+col, truncated to ADDR_W.
  - out_we=0 in every other state.
  - out_addr and out_data hold their values after the write.
- Counter advance after WRITE:
  - col wraps OUT_COLS-1 → 0 and increments row.
  - If the written pixel was (OUT_ROWS-1, OUT_COLS-1): pulse frame_done for 1 cycle, clear busy, go to IDLE.
  - Otherwise go to ACCEPT.
- add_res_tready:
  - 1 in WAIT1, WAIT2 and IDLE. In IDLE a stale post-reset result is drained and discarded.
  - 0 in all other states.
- Result handshakes:
  - A result valid outside a WAIT state while tready=0 stays pending on the adder side.
  - A result must never be accepted in ACCEPT, ISSUE1, ISSUE2 or WRITE.
- Latency: the scheduler adds no assumption on adder latency.
- Per-pixel cycles = 1 (ACCEPT) + 2 issue + 2×L_adder wait + 1 (WRITE), with zero backpressure.
- Arithmetic:
  - No fp interpretation inside this block.
  - The address product uses ADDR_W-bit unsigned arithmetic.

Test Plan:
1. Frame of 25 pixels, each in_data={0x4200,0x4000,0x3C00} (3.0, 2.0, 1.0), adder model latency 3 → 25 writes, each out_data=0x4600 (6.0). Addresses 0..24 in order; frame_done pulses once after addr 24; busy falls the same cycle.
2. add_b_tready delayed 4 cycles after add_a_tready in ISSUE1 → add_a_tvalid drops after its handshake. B is held stable with valid high until its tready. Exactly one add is issued; the result is correct.
3. in_valid deasserted for 10 cycles between pixels → in_ready stays 1 in ACCEPT; no adder traffic and no writes during the gap.
4. start pulsed mid-frame at pixel 7 → ignored. row/col continue; the total write count is still 25.
5. rst_n asserted during WAIT2 of pixel 12, then released, with the adder emitting a stale result 2 cycles later → outputs go to reset values immediately. The stale result is drained in IDLE with no write. A new start produces a fresh frame beginning at addr 0.
6. OUT_ROWS=2, OUT_COLS=3 → addresses 0,1,2,3,4,5; col wraps after 2; frame_done follows addr 5.
